// File: rtl/jtopl_pg_pkg.sv
// Shared constants for the OPL phase generator: slot count, accumulator
// width and the MULT factor table, plus the small arithmetic helpers.
package jtopl_pg_pkg;

  localparam int SLOTS  = 18;
  localparam int PW     = 19;
  localparam int SLOT_W = 5;
  localparam int FNUM_W = 10;
  localparam int INC_W  = 17;
  localparam int MUL_W  = 22;
  localparam int FACT_W = 5;
  localparam int OPH_W  = 10;

  // MULT field to frequency factor (x2 so that MULT=0 can mean 1/2)
  localparam logic [FACT_W-1:0] MUL_FACTOR [16] = '{
    5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
    5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
  };

  function automatic logic [FACT_W-1:0] mul_factor(input logic [3:0] mul);
    return MUL_FACTOR[mul];
  endfunction

  // Accumulator step: modulo 2^PW, the phase is meant to wrap freely
  function automatic logic [PW-1:0] phase_wrap_add(input logic [PW-1:0] phase,
                                                   input logic [PW-1:0] inc);
    logic [PW:0] sum;
    sum = {1'b0, phase} + {1'b0, inc};
    return sum[PW-1:0];
  endfunction

  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(SLOTS-1)) ? '0 : s + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/jtopl_pg_seq_if.sv
// Register-file fetch bus and operator-phase output bus of the phase
// generator sequencer.
interface jtopl_pg_seq_if;
  import jtopl_pg_pkg::*;

  logic [SLOT_W-1:0] slot;
  logic [FNUM_W-1:0] fnum;
  logic [2:0]        block;
  logic [3:0]        mul;
  logic              kon;
  logic              pg_test;
  logic [OPH_W-1:0]  phase_op;
  logic [SLOT_W-1:0] op_slot;
  logic              op_valid;

  // Sequencer side: addresses the register file and produces operator phase
  modport master (
    output slot, phase_op, op_slot, op_valid,
    input  fnum, block, mul, kon, pg_test
  );

  // Register file / operator stage side
  modport slave (
    input  slot, phase_op, op_slot, op_valid,
    output fnum, block, mul, kon, pg_test
  );
endinterface

// File: rtl/jtopl_pg_inc.sv
// Pure phase increment: F-number shifted by octave. Never overflows 17 bits
// (largest value is 0x3FF << 7 = 0x1FF80).
module jtopl_pg_inc
  import jtopl_pg_pkg::*;
(
  input  logic [FNUM_W-1:0] fnum,
  input  logic [2:0]        block,
  output logic [INC_W-1:0]  phinc_pure
);

  assign phinc_pure = {7'b0, fnum} << block;

endmodule

// File: rtl/jtopl_pg_sum.sv
// Phase-sum datapath: applies the MULT factor to the pure increment and
// either accumulates into the slot phase or forces it to zero.
module jtopl_pg_sum
  import jtopl_pg_pkg::*;
(
  input  logic [PW-1:0]    phase_in,
  input  logic [INC_W-1:0] phinc_pure,
  input  logic [3:0]       mul,
  input  logic             pg_rst,
  output logic [PW-1:0]    phase_out
);

  logic [MUL_W-1:0] phinc_mul;
  logic [PW-1:0]    phinc_step;

  // Factor table is doubled, so drop the LSB to get the real increment
  assign phinc_mul  = MUL_W'(phinc_pure) * MUL_W'(mul_factor(mul));
  assign phinc_step = phinc_mul[PW:1];
  assign phase_out  = pg_rst ? '0 : phase_wrap_add(phase_in, phinc_step);

endmodule

// File: rtl/jtopl_pg_seq.sv
// Time-multiplexed phase generator: walks the 18 operator slots, keeps each
// slot's 19-bit phase and key-on history, and emits the 10-bit operator phase.
module jtopl_pg_seq
  import jtopl_pg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  jtopl_pg_seq_if.master  bus
);

  logic [SLOT_W-1:0] slot_p0;
  logic [PW-1:0]     phase_mem [SLOTS];
  logic [SLOTS-1:0]  kon_prev;

  logic [INC_W-1:0]  phinc_pure;
  logic [PW-1:0]     phase_cur;
  logic [PW-1:0]     phase_nxt;
  logic              pg_rst;

  logic [OPH_W-1:0]  phase_op_p1;
  logic [SLOT_W-1:0] op_slot_p1;
  logic              vld_p1;

  // Stage A: fetch addressed slot, compute next phase combinationally
  assign phase_cur = phase_mem[slot_p0];
  // A held key-on must not keep resetting, so only the rising edge counts
  assign pg_rst    = bus.pg_test | (bus.kon & ~kon_prev[slot_p0]);

  jtopl_pg_inc u_inc (
    .fnum       (bus.fnum),
    .block      (bus.block),
    .phinc_pure (phinc_pure)
  );

  jtopl_pg_sum u_sum (
    .phase_in   (phase_cur),
    .phinc_pure (phinc_pure),
    .mul        (bus.mul),
    .pg_rst     (pg_rst),
    .phase_out  (phase_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_p0     <= '0;
      kon_prev    <= '0;
      for (int i = 0; i < SLOTS; i++) phase_mem[i] <= '0;
      phase_op_p1 <= '0;
      op_slot_p1  <= '0;
      vld_p1      <= 1'b0;
    end else if (cen) begin
      slot_p0            <= slot_next(slot_p0);
      phase_mem[slot_p0] <= phase_nxt;
      kon_prev[slot_p0]  <= bus.kon;
      // Output register: one cycle behind the addressed slot
      phase_op_p1        <= phase_nxt[PW-1:PW-OPH_W];
      op_slot_p1         <= slot_p0;
      vld_p1             <= 1'b1;
    end else begin
      vld_p1             <= 1'b0;
    end
  end

  assign bus.slot     = slot_p0;
  assign bus.phase_op = phase_op_p1;
  assign bus.op_slot  = op_slot_p1;
  assign bus.op_valid = vld_p1;

endmodule

// File: tb/tb_jtopl_pg_seq.sv
// Randomized and directed bench for jtopl_pg_seq against a slot-level
// reference model of the phase accumulators.
module tb_jtopl_pg_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;

  jtopl_pg_seq_if bus();

  jtopl_pg_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file contents, addressed by the DUT's slot output
  logic [9:0] fnum_t [18];
  logic [2:0] blk_t  [18];
  logic [3:0] mul_t  [18];
  logic       kon_t  [18];

  always_comb begin
    bus.fnum  = '0;
    bus.block = '0;
    bus.mul   = '0;
    bus.kon   = 1'b0;
    if (bus.slot < 5'd18) begin
      bus.fnum  = fnum_t[bus.slot];
      bus.block = blk_t[bus.slot];
      bus.mul   = mul_t[bus.slot];
      bus.kon   = kon_t[bus.slot];
    end
  end

  int fact [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};

  int unsigned m_phase [18];
  bit          m_konp  [18];
  int          m_slot, m_op_slot, m_phase_op;
  bit          m_vld;
  int          last_op [18];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 18; i++) begin
      m_phase[i] = 0;
      m_konp[i]  = 1'b0;
      last_op[i] = 0;
    end
    m_slot = 0; m_op_slot = 0; m_phase_op = 0; m_vld = 1'b0;
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 18; i++) begin
      fnum_t[i] = '0; blk_t[i] = '0; mul_t[i] = '0; kon_t[i] = 1'b0;
    end
  endtask

  // One clock: entered and left on the falling edge
  task automatic cycle(input bit c);
    int s, inc;
    bit rs;
    cen = c;
    if (c) begin
      s   = m_slot;
      inc = ((int'(fnum_t[s]) * (1 << blk_t[s]) * fact[mul_t[s]]) / 2) % (1 << 19);
      rs  = bus.pg_test || (kon_t[s] && !m_konp[s]);
      m_phase[s] = rs ? 0 : (m_phase[s] + inc) % (1 << 19);
      m_konp[s]  = kon_t[s];
      m_op_slot  = s;
      m_phase_op = m_phase[s] / 512;
      m_vld      = 1'b1;
      m_slot     = (s + 1) % 18;
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("slot", 32'(bus.slot), 32'(m_slot));
    chk("op_valid", 32'(bus.op_valid), 32'(m_vld));
    chk("op_slot", 32'(bus.op_slot), 32'(m_op_slot));
    chk("phase_op", 32'(bus.phase_op), 32'(m_phase_op));
    if (bus.op_valid && bus.op_slot < 5'd18) last_op[bus.op_slot] = int'(bus.phase_op);
    @(negedge clk);
  endtask

  task automatic sweep(input int n);
    for (int i = 0; i < n * 18; i++) cycle(1'b1);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock
  task automatic do_reset();
    cen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_slot", 32'(bus.slot), 32'd0);
    chk("rst_op_slot", 32'(bus.op_slot), 32'd0);
    chk("rst_phase_op", 32'(bus.phase_op), 32'd0);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pg_test = 1'b0;
    clear_regs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Idle sweep: all inputs zero
    sweep(1);
    cycle(1'b1);

    // Slot 3 creeping by one per visit
    do_reset();
    fnum_t[3] = 10'd1; mul_t[3] = 4'd1;
    sweep(512);
    chk("t2_ph3", 32'(last_op[3]), 32'd1);
    chk("t2_ph4", 32'(last_op[4]), 32'd0);

    // Slot 0 large step, wraps on eighth visit
    do_reset();
    clear_regs();
    fnum_t[0] = 10'h200; blk_t[0] = 3'd7; mul_t[0] = 4'd1;
    for (int v = 1; v <= 8; v++) begin
      sweep(1);
      chk("t3_ph0", 32'(last_op[0]), 32'((128 * v) % 1024));
    end

    // Key-on edge on slot 5 while running
    do_reset();
    clear_regs();
    fnum_t[5] = 10'h200; blk_t[5] = 3'd7; mul_t[5] = 4'd1;
    sweep(3);
    chk("t4_run", 32'(last_op[5]), 32'd384);
    kon_t[5] = 1'b1;
    sweep(1);
    chk("t4_kon", 32'(last_op[5]), 32'd0);
    sweep(1);
    chk("t4_held", 32'(last_op[5]), 32'd128);
    kon_t[5] = 1'b0;
    sweep(1);
    chk("t4_koff", 32'(last_op[5]), 32'd256);

    // pg_test for one sweep with all slots running
    for (int i = 0; i < 18; i++) begin
      fnum_t[i] = 10'($urandom_range(1023, 1)); blk_t[i] = 3'($urandom);
      mul_t[i] = 4'($urandom); kon_t[i] = 1'($urandom);
    end
    sweep(2);
    bus.pg_test = 1'b1;
    sweep(1);
    for (int i = 0; i < 18; i++) chk("t5_pgtest", 32'(last_op[i]), 32'd0);
    bus.pg_test = 1'b0;
    sweep(1);

    // Alternating cen with reset pulse at slot 11
    for (int i = 0; i < 60 && m_slot != 11; i++) cycle(i % 2 == 0);
    chk("t6_at11", 32'(bus.slot), 32'd11);
    do_reset();
    cycle(1'b1);
    chk("t6_first", 32'(bus.op_slot), 32'd0);
    for (int i = 0; i < 40; i++) cycle(i % 2 == 1);

    // Random settings, random cen, random key and test bits
    for (int r = 0; r < 3000; r++) begin
      if ($urandom_range(7, 0) == 0) begin
        int k;
        k = $urandom_range(17, 0);
        fnum_t[k] = 10'($urandom); blk_t[k] = 3'($urandom);
        mul_t[k] = 4'($urandom);
      end
      if ($urandom_range(15, 0) == 0) kon_t[$urandom_range(17, 0)] = 1'($urandom);
      bus.pg_test = ($urandom_range(99, 0) == 0);
      cycle($urandom_range(3, 0) != 0);
    end
    bus.pg_test = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
